// File: rtl/udp_tx_framer.sv
// Ethernet II / IPv4 / UDP transmit framer: prepends a 42-byte header to a 32-bit payload
// stream and realigns the payload by two bytes through a 16-bit hold register.
module udp_tx_framer #(
  parameter int          STREAM_DATA_WIDTH = 32,
  parameter logic [47:0] SRC_MAC           = 48'h00350a000201,
  parameter logic [47:0] DST_MAC           = 48'hffffffffffff,
  parameter logic [31:0] SRC_IP            = 32'hc0a8120a,
  parameter logic [31:0] DST_IP            = 32'hc0a81201,
  parameter logic [15:0] SRC_PORT          = 16'h1f90,
  parameter logic [15:0] DST_PORT          = 16'h1f90,
  parameter int          PAYLOAD_MAX_SIZE  = 1472
) (
  input  logic                           clk_i,
  input  logic                           s_rst_i,
  input  logic [15:0]                    tx_len_i,
  input  logic                           tx_len_valid_i,
  output logic                           tx_len_ready_o,
  output logic                           drop_o,
  input  logic [STREAM_DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [STREAM_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic                           s_axis_tvalid_i,
  input  logic                           s_axis_tlast_i,
  output logic                           s_axis_tready_o,
  output logic [STREAM_DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [STREAM_DATA_WIDTH/8-1:0] m_axis_tkeep_o,
  output logic                           m_axis_tvalid_o,
  output logic                           m_axis_tlast_o,
  input  logic                           m_axis_tready_i
);

  typedef enum logic [2:0] {IDLE, HEADER, SPLICE, PAYLOAD, FLUSH} state_t;

  state_t      state, state_next;
  logic [3:0]  word_cnt, word_cnt_next;
  logic [15:0] len, len_next;
  logic [15:0] beats_left, beats_left_next;
  logic [15:0] hold, hold_next;
  logic [15:0] csum, csum_next;

  logic [15:0] total_len, udp_len;
  logic [31:0] header_word;
  logic [1:0]  tail;
  logic [3:0]  last_keep;
  logic        needs_flush;

  // Framing comes from the requested length, so the input sideband is deliberately unused.
  logic unused_sideband;
  assign unused_sideband = &{1'b0, s_axis_tkeep_i, s_axis_tlast_i};

  function automatic logic [15:0] ip_checksum(input logic [15:0] tot_len);
    logic [31:0] sum;
    sum = 32'h4500 + 32'(tot_len) + 32'h0000 + 32'h4000 + 32'h4011
        + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0]) + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    sum = 32'(sum[15:0]) + 32'(sum[31:16]);
    return ~sum[15:0];
  endfunction

  function automatic logic [15:0] swap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  assign total_len   = len + 16'd28;
  assign udp_len     = len + 16'd8;
  assign tail        = len[1:0] + 2'd2;
  assign needs_flush = (len[1:0] == 2'd0) || (len[1:0] == 2'd3);

  always_comb begin
    unique case (tail)
      2'd0:    last_keep = 4'b1111;
      2'd1:    last_keep = 4'b0001;
      2'd2:    last_keep = 4'b0011;
      default: last_keep = 4'b0111;
    endcase
  end

  // Header words are little-endian on the bus: lane 0 carries the earliest wire byte.
  always_comb begin
    case (word_cnt)
      4'd0:    header_word = {swap16(DST_MAC[31:16]), swap16(DST_MAC[47:32])};
      4'd1:    header_word = {swap16(SRC_MAC[47:32]), swap16(DST_MAC[15:0])};
      4'd2:    header_word = {swap16(SRC_MAC[15:0]), swap16(SRC_MAC[31:16])};
      4'd3:    header_word = 32'h00450008;
      4'd4:    header_word = {16'h0000, swap16(total_len)};
      4'd5:    header_word = 32'h11400040;
      4'd6:    header_word = {swap16(SRC_IP[31:16]), swap16(csum)};
      4'd7:    header_word = {swap16(DST_IP[31:16]), swap16(SRC_IP[15:0])};
      4'd8:    header_word = {swap16(SRC_PORT), swap16(DST_IP[15:0])};
      4'd9:    header_word = {swap16(udp_len), swap16(DST_PORT)};
      default: header_word = '0;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    word_cnt_next   = word_cnt;
    len_next        = len;
    beats_left_next = beats_left;
    hold_next       = hold;
    csum_next       = csum;
    tx_len_ready_o  = 1'b0;
    drop_o          = 1'b0;
    s_axis_tready_o = 1'b0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tdata_o  = '0;
    m_axis_tkeep_o  = 4'b1111;
    m_axis_tlast_o  = 1'b0;

    unique case (state)
      IDLE: begin
        tx_len_ready_o = !s_rst_i;
        if (tx_len_valid_i && !s_rst_i) begin
          if (tx_len_i > 16'(PAYLOAD_MAX_SIZE)) begin
            drop_o = 1'b1;
          end else begin
            len_next        = tx_len_i;
            beats_left_next = (tx_len_i + 16'd3) >> 2;
            csum_next       = ip_checksum(tx_len_i + 16'd28);
            word_cnt_next   = 4'd0;
            state_next      = HEADER;
          end
        end
      end

      HEADER: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = header_word;
        if (m_axis_tready_i) begin
          word_cnt_next = word_cnt + 4'd1;
          if (word_cnt == 4'd9) state_next = SPLICE;
        end
      end

      SPLICE: begin
        if (len == 16'd0) begin
          m_axis_tvalid_o = 1'b1;
          m_axis_tkeep_o  = last_keep;
          m_axis_tlast_o  = 1'b1;
          if (m_axis_tready_i) state_next = IDLE;
        end else begin
          s_axis_tready_o = m_axis_tready_i;
          m_axis_tvalid_o = s_axis_tvalid_i;
          m_axis_tdata_o  = {s_axis_tdata_i[15:0], 16'h0000};
          if (len <= 16'd2) begin
            m_axis_tkeep_o = last_keep;
            m_axis_tlast_o = 1'b1;
          end
          if (s_axis_tvalid_i && m_axis_tready_i) begin
            hold_next       = s_axis_tdata_i[31:16];
            beats_left_next = beats_left - 16'd1;
            if (len <= 16'd2)            state_next = IDLE;
            else if (beats_left == 16'd1) state_next = FLUSH;
            else                          state_next = PAYLOAD;
          end
        end
      end

      PAYLOAD: begin
        s_axis_tready_o = m_axis_tready_i;
        m_axis_tvalid_o = s_axis_tvalid_i;
        m_axis_tdata_o  = {s_axis_tdata_i[15:0], hold};
        if (beats_left == 16'd1 && !needs_flush) begin
          m_axis_tkeep_o = last_keep;
          m_axis_tlast_o = 1'b1;
        end
        if (s_axis_tvalid_i && m_axis_tready_i) begin
          hold_next       = s_axis_tdata_i[31:16];
          beats_left_next = beats_left - 16'd1;
          if (beats_left == 16'd1) state_next = needs_flush ? FLUSH : IDLE;
        end
      end

      FLUSH: begin
        m_axis_tvalid_o = 1'b1;
        m_axis_tdata_o  = {16'h0000, hold};
        m_axis_tkeep_o  = last_keep;
        m_axis_tlast_o  = 1'b1;
        if (m_axis_tready_i) state_next = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together
  // from values sampled at the same clock edge.
  always_ff @(posedge clk_i) begin
    if (s_rst_i) begin
      state      <= IDLE;
      word_cnt   <= '0;
      len        <= '0;
      beats_left <= '0;
      hold       <= '0;
      csum       <= '0;
    end else begin
      state      <= state_next;
      word_cnt   <= word_cnt_next;
      len        <= len_next;
      beats_left <= beats_left_next;
      hold       <= hold_next;
      csum       <= csum_next;
    end
  end

endmodule

// File: tb/tb_udp_tx_framer.sv
// Directed self-checking bench for udp_tx_framer: builds each expected frame byte by byte
// from the header layout and compares every output beat.
module tb_udp_tx_framer;

  logic        clk_i = 1'b0;
  logic        s_rst_i = 1'b1;
  logic [15:0] tx_len_i = '0;
  logic        tx_len_valid_i = 1'b0;
  logic        tx_len_ready_o;
  logic        drop_o;
  logic [31:0] s_axis_tdata_i = '0;
  logic [3:0]  s_axis_tkeep_i = 4'hf;
  logic        s_axis_tvalid_i = 1'b0;
  logic        s_axis_tlast_i = 1'b0;
  logic        s_axis_tready_o;
  logic [31:0] m_axis_tdata_o;
  logic [3:0]  m_axis_tkeep_o;
  logic        m_axis_tvalid_o;
  logic        m_axis_tlast_o;
  logic        m_axis_tready_i = 1'b0;

  always #5 clk_i = ~clk_i;

  udp_tx_framer dut (
    .clk_i           (clk_i),
    .s_rst_i         (s_rst_i),
    .tx_len_i        (tx_len_i),
    .tx_len_valid_i  (tx_len_valid_i),
    .tx_len_ready_o  (tx_len_ready_o),
    .drop_o          (drop_o),
    .s_axis_tdata_i  (s_axis_tdata_i),
    .s_axis_tkeep_i  (s_axis_tkeep_i),
    .s_axis_tvalid_i (s_axis_tvalid_i),
    .s_axis_tlast_i  (s_axis_tlast_i),
    .s_axis_tready_o (s_axis_tready_o),
    .m_axis_tdata_o  (m_axis_tdata_o),
    .m_axis_tkeep_o  (m_axis_tkeep_o),
    .m_axis_tvalid_o (m_axis_tvalid_o),
    .m_axis_tlast_o  (m_axis_tlast_o),
    .m_axis_tready_i (m_axis_tready_i)
  );

  logic [47:0] dst_mac = 48'hffffffffffff;
  logic [47:0] src_mac = 48'h00350a000201;
  logic [31:0] src_ip  = 32'hc0a8120a;
  logic [31:0] dst_ip  = 32'hc0a81201;
  logic [15:0] src_port = 16'h1f90;
  logic [15:0] dst_port = 16'h1f90;

  int tests = 0;
  int fails = 0;

  logic [31:0] got_data[$];
  logic [3:0]  got_keep[$];
  logic        got_last[$];
  int          n_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [15:0] ip_csum(input logic [15:0] tl);
    logic [31:0] s;
    s = 32'h4500 + 32'(tl) + 32'h4000 + 32'h4011
      + 32'(src_ip[31:16]) + 32'(src_ip[15:0]) + 32'(dst_ip[31:16]) + 32'(dst_ip[15:0]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  function automatic logic [31:0] payload_word(input logic [7:0] start, input int idx);
    logic [7:0] b;
    b = start + 8'(idx);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Drives one frame: length handshake, payload source and sink, optional reset at a given beat.
  task automatic run_frame(input int len, input logic [7:0] start, input bit gaps, input int rst_at);
    int pay_idx = 0;
    int cyc = 0;
    bit done = 0;
    bit s_fire = 0;
    bit s_pend = 0;
    bit stall = 0;
    logic [31:0] pdata = '0;
    logic [4:0]  pctl = '0;
    n_in = 0;
    got_data.delete(); got_keep.delete(); got_last.delete();
    @(negedge clk_i);
    s_axis_tvalid_i = 1'b0;
    tx_len_i        = 16'(len);
    tx_len_valid_i  = 1'b1;
    m_axis_tready_i = 1'b1;
    #1;
    check($sformatf("L%0d_len_ready", len), 32'(tx_len_ready_o), 32'd1);
    check($sformatf("L%0d_no_drop", len), 32'(drop_o), 32'd0);
    while (!done && cyc < 4000) begin
      @(negedge clk_i);
      tx_len_valid_i = 1'b0;
      if (s_fire) pay_idx += 4;
      if (!s_pend) begin
        if (pay_idx < len && (!gaps || $urandom_range(0, 99) < 70)) begin
          s_axis_tvalid_i = 1'b1;
          s_axis_tdata_i  = payload_word(start, pay_idx);
        end else begin
          s_axis_tvalid_i = 1'b0;
        end
      end
      m_axis_tready_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_at >= 0 && got_data.size() == rst_at) begin
        s_rst_i = 1'b1;
        #1;
        check("rst_len_ready_low", 32'(tx_len_ready_o), 32'd0);
        @(negedge clk_i);
        s_rst_i         = 1'b0;
        s_axis_tvalid_i = 1'b0;
        #1;
        check("rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast_o), 32'd0);
        check("rst_s_tready", 32'(s_axis_tready_o), 32'd0);
        check("rst_len_ready", 32'(tx_len_ready_o), 32'd1);
        done = 1;
      end else begin
        #1;
        if (cyc == 0) check($sformatf("L%0d_w0_latency", len), 32'(m_axis_tvalid_o), 32'd1);
        if (stall) begin
          check($sformatf("L%0d_stable_valid", len), 32'(m_axis_tvalid_o), 32'd1);
          check($sformatf("L%0d_stable_data", len), m_axis_tdata_o, pdata);
          check($sformatf("L%0d_stable_ctl", len), 32'({m_axis_tlast_o, m_axis_tkeep_o}), 32'(pctl));
        end
        s_fire = s_axis_tvalid_i && s_axis_tready_o;
        s_pend = s_axis_tvalid_i && !s_fire;
        stall  = m_axis_tvalid_o && !m_axis_tready_i;
        pdata  = m_axis_tdata_o;
        pctl   = {m_axis_tlast_o, m_axis_tkeep_o};
        if (m_axis_tvalid_o && m_axis_tready_i) begin
          got_data.push_back(m_axis_tdata_o);
          got_keep.push_back(m_axis_tkeep_o);
          got_last.push_back(m_axis_tlast_o);
          if (m_axis_tlast_o) done = 1;
        end
        if (s_fire) n_in++;
        cyc++;
      end
    end
    check($sformatf("L%0d_completed", len), 32'(done), 32'd1);
    if (!gaps && rst_at < 0)
      check($sformatf("L%0d_cycles", len), 32'(cyc), 32'((42 + len + 3) / 4));
  endtask

  task automatic compare_frame(input int len, input logic [7:0] start);
    logic [7:0]  eb[$];
    logic [15:0] tl, ul, cs;
    int          nb, rem;
    logic [3:0]  lk;
    tl = 16'(28 + len);
    ul = 16'(8 + len);
    cs = ip_csum(tl);
    for (int i = 0; i < 6; i++) eb.push_back(dst_mac[47 - 8*i -: 8]);
    for (int i = 0; i < 6; i++) eb.push_back(src_mac[47 - 8*i -: 8]);
    eb.push_back(8'h08); eb.push_back(8'h00); eb.push_back(8'h45); eb.push_back(8'h00);
    eb.push_back(tl[15:8]); eb.push_back(tl[7:0]); eb.push_back(8'h00); eb.push_back(8'h00);
    eb.push_back(8'h40); eb.push_back(8'h00); eb.push_back(8'h40); eb.push_back(8'h11);
    eb.push_back(cs[15:8]); eb.push_back(cs[7:0]);
    for (int i = 0; i < 4; i++) eb.push_back(src_ip[31 - 8*i -: 8]);
    for (int i = 0; i < 4; i++) eb.push_back(dst_ip[31 - 8*i -: 8]);
    eb.push_back(src_port[15:8]); eb.push_back(src_port[7:0]);
    eb.push_back(dst_port[15:8]); eb.push_back(dst_port[7:0]);
    eb.push_back(ul[15:8]); eb.push_back(ul[7:0]); eb.push_back(8'h00); eb.push_back(8'h00);
    for (int i = 0; i < len; i++) eb.push_back(start + 8'(i));
    nb  = (42 + len + 3) / 4;
    rem = (42 + len) % 4;
    lk  = (rem == 0) ? 4'hf : (4'hf >> (4 - rem));
    check($sformatf("L%0d_beats", len), 32'(got_data.size()), 32'(nb));
    check($sformatf("L%0d_inputs", len), 32'(n_in), 32'((len + 3) / 4));
    for (int b = 0; b < nb && b < got_data.size(); b++) begin
      logic [31:0] ew, mask;
      logic [3:0]  ek;
      ek = (b == nb - 1) ? lk : 4'hf;
      ew = '0;
      mask = '0;
      for (int l = 0; l < 4; l++) begin
        if (ek[l]) begin
          ew[8*l +: 8]   = eb[4*b + l];
          mask[8*l +: 8] = 8'hff;
        end
      end
      check($sformatf("L%0d_w%0d_data", len, b), got_data[b] & mask, ew);
      check($sformatf("L%0d_w%0d_ctl", len, b), 32'({got_last[b], got_keep[b]}),
            32'({b == nb - 1, ek}));
    end
  endtask

  task automatic drop_req(input int len);
    @(negedge clk_i);
    s_axis_tvalid_i = 1'b0;
    m_axis_tready_i = 1'b1;
    tx_len_i        = 16'(len);
    tx_len_valid_i  = 1'b1;
    #1;
    check($sformatf("L%0d_drop_pulse", len), 32'(drop_o), 32'd1);
    check($sformatf("L%0d_drop_ready", len), 32'(tx_len_ready_o), 32'd1);
    @(negedge clk_i);
    tx_len_valid_i = 1'b0;
    #1;
    check($sformatf("L%0d_drop_single", len), 32'(drop_o), 32'd0);
    check($sformatf("L%0d_drop_no_out", len), 32'(m_axis_tvalid_o), 32'd0);
    check($sformatf("L%0d_drop_ready_after", len), 32'(tx_len_ready_o), 32'd1);
  endtask

  initial begin
    @(negedge clk_i);
    #1;
    check("reset_len_ready", 32'(tx_len_ready_o), 32'd0);
    check("reset_tvalid", 32'(m_axis_tvalid_o), 32'd0);
    check("reset_tlast", 32'(m_axis_tlast_o), 32'd0);
    check("reset_s_tready", 32'(s_axis_tready_o), 32'd0);
    check("reset_drop", 32'(drop_o), 32'd0);
    @(negedge clk_i);
    s_rst_i = 1'b0;
    #1;
    check("post_reset_len_ready", 32'(tx_len_ready_o), 32'd1);

    run_frame(18, 8'h00, 1'b0, -1);
    compare_frame(18, 8'h00);
    check("L18_w4_full", got_data[4], 32'h00002e00);
    check("L18_w6_full", got_data[6], 32'ha8c06395);
    check("L18_w10_full", got_data[10], 32'h01000000);

    run_frame(4, 8'h00, 1'b0, -1);
    compare_frame(4, 8'h00);
    check("L4_flush_full", got_data[11], 32'h00000302);

    run_frame(1, 8'h5a, 1'b0, -1);
    compare_frame(1, 8'h5a);

    run_frame(0, 8'h00, 1'b0, -1);
    compare_frame(0, 8'h00);
    check("L0_splice_full", got_data[10], 32'h00000000);

    run_frame(7, 8'h30, 1'b0, -1);
    compare_frame(7, 8'h30);

    drop_req(1500);
    drop_req(1473);

    run_frame(1472, 8'h10, 1'b0, -1);
    compare_frame(1472, 8'h10);

    run_frame(64, 8'h80, 1'b1, -1);
    compare_frame(64, 8'h80);

    run_frame(18, 8'h00, 1'b0, 7);
    run_frame(18, 8'h00, 1'b0, -1);
    compare_frame(18, 8'h00);
    check("L18_after_rst_w6", got_data[6], 32'ha8c06395);

    @(negedge clk_i);
    s_axis_tvalid_i = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
